// File: rtl/svm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svm_sched_pkg
// Description : Shared widths, counter limit and saturating increment for the
//               scheduler ingress path.
// Revision    : 1.0 - initial release
// ============================================================================
package svm_sched_pkg;

    localparam int PROGRAM_ID_W = 64;
    localparam int PERF_CNT_W   = 32;

    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        return (value == PERF_CNT_MAX) ? value : value + PERF_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector; one-hot grant to the first
//               requester at or above the pointer, wrapping to port 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PORT_W-1:0]    i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic              w_found;
    logic [PORT_W:0]   w_sum;
    logic [PORT_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, i_ptr} + (PORT_W+1)'(k);
            if (w_sum >= (PORT_W+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (PORT_W+1)'(NUM_PORTS);
            end
            w_idx = w_sum[PORT_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ingress_arbiter
// Description : Round-robin merge of NUM_PORTS transaction streams into one
//               registered output slot, with per-port grant and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ingress_arbiter
    import svm_sched_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int MAX_DEPENDENCIES = 256,
    parameter int PORT_W           = $clog2(NUM_PORTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    input  logic [PROGRAM_ID_W*NUM_PORTS-1:0]    s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES*NUM_PORTS-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES*NUM_PORTS-1:0] s_axis_tdata_write_dependencies,
    input  logic                                 hold,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [PROGRAM_ID_W-1:0]              m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0]          m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0]          m_axis_tdata_write_dependencies,
    output logic [PORT_W-1:0]                    m_axis_tuser_port,
    output logic [PERF_CNT_W*NUM_PORTS-1:0]      grant_count,
    output logic [PERF_CNT_W-1:0]                stall_cycles
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_next;
    logic [PORT_W-1:0]           r_rr_ptr;
    logic [PROGRAM_ID_W-1:0]     r_pid;
    logic [MAX_DEPENDENCIES-1:0] r_rd_deps;
    logic [MAX_DEPENDENCIES-1:0] r_wr_deps;
    logic [PORT_W-1:0]           r_port;
    logic [PERF_CNT_W-1:0]       r_stall;

    logic                        w_load_en;
    logic                        w_accept;
    logic [NUM_PORTS-1:0]        w_grant;
    logic [PORT_W-1:0]           w_grant_idx;
    logic [PROGRAM_ID_W-1:0]     w_sel_pid;
    logic [MAX_DEPENDENCIES-1:0] w_sel_rd;
    logic [MAX_DEPENDENCIES-1:0] w_sel_wr;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_arbiter (
        .i_req   (s_axis_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // Reset gates acceptance so nothing is handshaken while the slot is being cleared.
    assign w_accept      = w_load_en & ~hold & ~rst & (|w_grant);
    assign s_axis_tready = w_accept ? w_grant : '0;

    always_comb begin
        w_grant_idx = '0;
        w_sel_pid   = '0;
        w_sel_rd    = '0;
        w_sel_wr    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = PORT_W'(i);
                w_sel_pid   = s_axis_tdata_owner_programID[i*PROGRAM_ID_W +: PROGRAM_ID_W];
                w_sel_rd    = s_axis_tdata_read_dependencies[i*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
                w_sel_wr    = s_axis_tdata_write_dependencies[i*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_FULL;
            S_FULL:  if (!w_accept && m_axis_tready) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (r_state == S_FULL);
        w_load_en     = (r_state == S_EMPTY) || m_axis_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_pid     <= '0;
            r_rd_deps <= '0;
            r_wr_deps <= '0;
            r_port    <= '0;
        end else if (w_accept) begin
            r_rr_ptr  <= (w_grant_idx == PORT_W'(NUM_PORTS-1)) ? '0 : w_grant_idx + PORT_W'(1);
            r_pid     <= w_sel_pid;
            r_rd_deps <= w_sel_rd;
            r_wr_deps <= w_sel_wr;
            r_port    <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == S_FULL) && !m_axis_tready) begin
            r_stall <= sat_inc(r_stall);
        end
    end

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
            logic [PERF_CNT_W-1:0] r_count;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (w_accept && w_grant[g]) begin
                    r_count <= sat_inc(r_count);
                end
            end
            assign grant_count[g*PERF_CNT_W +: PERF_CNT_W] = r_count;
        end
    endgenerate

    assign m_axis_tdata_owner_programID    = r_pid;
    assign m_axis_tdata_read_dependencies  = r_rd_deps;
    assign m_axis_tdata_write_dependencies = r_wr_deps;
    assign m_axis_tuser_port               = r_port;
    assign stall_cycles                    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ingress_arbiter
// Description : Directed self-checking bench for ingress_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ingress_arbiter;

    localparam int NP = 4;
    localparam int MD = 256;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [64*NP-1:0]  s_pid;
    logic [MD*NP-1:0]  s_rd;
    logic [MD*NP-1:0]  s_wr;
    logic              hold;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [63:0]       m_pid;
    logic [MD-1:0]     m_rd;
    logic [MD-1:0]     m_wr;
    logic [PW-1:0]     m_port;
    logic [32*NP-1:0]  grant_count;
    logic [31:0]       stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ingress_arbiter #(.NUM_PORTS(NP), .MAX_DEPENDENCIES(MD), .PORT_W(PW)) dut (
        .clk                             (clk),
        .rst                             (rst),
        .s_axis_tvalid                   (s_axis_tvalid),
        .s_axis_tready                   (s_axis_tready),
        .s_axis_tdata_owner_programID    (s_pid),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .hold                            (hold),
        .m_axis_tvalid                   (m_axis_tvalid),
        .m_axis_tready                   (m_axis_tready),
        .m_axis_tdata_owner_programID    (m_pid),
        .m_axis_tdata_read_dependencies  (m_rd),
        .m_axis_tdata_write_dependencies (m_wr),
        .m_axis_tuser_port               (m_port),
        .grant_count                     (grant_count),
        .stall_cycles                    (stall_cycles)
    );

    function automatic logic [63:0] pid_of(int p);
        return 64'hC0DE_0000_0000_0010 + 64'(p);
    endfunction

    function automatic logic [MD-1:0] rd_of(int p);
        return {8{32'h5EAD_0000 + 32'(p)}};
    endfunction

    function automatic logic [MD-1:0] wr_of(int p);
        return {8{32'hB00B_0000 + 32'(p)}};
    endfunction

    task automatic check(input string tag, input logic [MD-1:0] got, input logic [MD-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int p);
        check({tag, "_valid"}, MD'(m_axis_tvalid), MD'(1));
        check({tag, "_port"},  MD'(m_port), MD'(p));
        check({tag, "_pid"},   MD'(m_pid), MD'(pid_of(p)));
        check({tag, "_rd"},    m_rd, rd_of(p));
        check({tag, "_wr"},    m_wr, wr_of(p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gc(int p);
        return grant_count[32*p +: 32];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        hold          = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = '0;
        for (int p = 0; p < NP; p++) begin
            s_pid[64*p +: 64] = pid_of(p);
            s_rd[MD*p +: MD]  = rd_of(p);
            s_wr[MD*p +: MD]  = wr_of(p);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_mvalid", MD'(m_axis_tvalid), MD'(0));
        check("rst_sready", MD'(s_axis_tready), MD'(0));
        check("rst_gcount", MD'(grant_count), MD'(0));
        check("rst_stall",  MD'(stall_cycles), MD'(0));
        check("rst_pid",    MD'(m_pid), MD'(0));
        check("rst_rd",     m_rd, MD'(0));
        rst = 1'b0;

        // All ports valid, sink always ready: one beat per cycle in port order.
        s_axis_tvalid = 4'hF;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_sready", MD'(s_axis_tready), MD'(4'b0001 << (k % 4)));
            tick();
            check_beat("rr_beat", k % 4);
        end
        s_axis_tvalid = '0;
        tick();
        check("rr_drain", MD'(m_axis_tvalid), MD'(0));
        for (int p = 0; p < NP; p++) check("rr_gcount", MD'(gc(p)), MD'(2));

        // Pointer moved to 2 by a lone port-1 beat, then ports 1 and 3 compete.
        s_axis_tvalid = 4'b0010;
        tick();
        check_beat("wrap_first", 1);
        check("wrap_ptr", MD'(dut.r_rr_ptr), MD'(2));
        s_axis_tvalid = 4'b1010;
        tick();
        check_beat("wrap_p3", 3);
        tick();
        check_beat("wrap_p1", 1);
        s_axis_tvalid = '0;
        tick();
        check("wrap_drain", MD'(m_axis_tvalid), MD'(0));

        // Back-pressure: slot stays full and stable, nothing accepted.
        m_axis_tready = 1'b0;
        s_axis_tvalid = 4'b0001;
        tick();
        check_beat("stall_load", 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_sready", MD'(s_axis_tready), MD'(0));
            tick();
            check_beat("stall_hold", 0);
        end
        check("stall_count", MD'(stall_cycles), MD'(5));
        m_axis_tready = 1'b1;
        #1;
        check("refill_sready", MD'(s_axis_tready), MD'(4'b0001));
        tick();
        check_beat("refill", 0);
        check("refill_gc0", MD'(gc(0)), MD'(4));

        // Hold: slot drains, no acceptance until hold drops.
        hold          = 1'b1;
        s_axis_tvalid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_sready", MD'(s_axis_tready), MD'(0));
            tick();
            check("hold_mvalid", MD'(m_axis_tvalid), MD'(0));
        end
        hold = 1'b0;
        #1;
        check("hold_release_sready", MD'(s_axis_tready), MD'(4'b0010));
        tick();
        check_beat("hold_release", 1);
        check("hold_stall", MD'(stall_cycles), MD'(5));

        // Asynchronous reset mid-operation with grant_count[0] at 7.
        s_axis_tvalid = 4'b0001;
        repeat (3) tick();
        check("pre_rst_gc0", MD'(gc(0)), MD'(7));
        check_beat("pre_rst", 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mvalid", MD'(m_axis_tvalid), MD'(0));
        check("arst_gcount", MD'(grant_count), MD'(0));
        check("arst_ptr",    MD'(dut.r_rr_ptr), MD'(0));
        check("arst_stall",  MD'(stall_cycles), MD'(0));
        check("arst_sready", MD'(s_axis_tready), MD'(0));
        check("arst_pid",    MD'(m_pid), MD'(0));
        tick();
        check("arst_noacc", MD'(m_axis_tvalid), MD'(0));
        rst           = 1'b0;
        s_axis_tvalid = 4'b0110;
        #1;
        check("post_rst_sready", MD'(s_axis_tready), MD'(4'b0010));
        tick();
        check_beat("post_rst", 1);
        check("post_rst_gc1", MD'(gc(1)), MD'(1));

        // Saturation of grant_count[2].
        s_axis_tvalid = '0;
        tick();
        force dut.g_cnt[2].r_count = 32'hFFFF_FFFE;
        #1;
        release dut.g_cnt[2].r_count;
        s_axis_tvalid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_beat("sat_beat", 2);
        end
        check("sat_gc2", MD'(gc(2)), MD'(32'hFFFF_FFFF));
        s_axis_tvalid = '0;
        tick();
        check("sat_drain", MD'(m_axis_tvalid), MD'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
